// File: rtl/controlador_senha_param.sv
// Parametrised keypad lock controller: collects BCD digits, compares a full code,
// counts failures into a timed lockout, and allows reprogramming while open.
module controlador_senha_param #(
    parameter int                      CODE_LEN       = 6,
    parameter int                      MAX_TRIES      = 3,
    parameter int                      LOCKOUT_CYCLES = 16,
    parameter int                      TIMEOUT_CYCLES = 32,
    parameter logic [4*CODE_LEN-1:0]   DEFAULT_CODE   = 24'h589204
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       insere,
    input  logic [3:0] numero,
    input  logic       programa,
    input  logic       trava,
    output logic [3:0] estado,
    output logic [1:0] modo,
    output logic [6:0] display,
    output logic       led,
    output logic       bloqueado,
    output logic       erro,
    output logic [3:0] tentativas
);

    typedef enum logic [1:0] {
        ST_ENTRY = 2'd0,
        ST_OPEN  = 2'd1,
        ST_PROG  = 2'd2,
        ST_LOCK  = 2'd3
    } state_t;

    localparam int TMAXC = (LOCKOUT_CYCLES > TIMEOUT_CYCLES) ? LOCKOUT_CYCLES : TIMEOUT_CYCLES;
    localparam int TW    = $clog2(TMAXC + 1);

    localparam logic [TW-1:0] T_SAT   = '1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] LK_LAST = TW'(LOCKOUT_CYCLES - 1);
    localparam logic [3:0]    LAST    = 4'(CODE_LEN - 1);
    localparam logic [3:0]    MAXT    = 4'(MAX_TRIES);
    localparam logic [6:0]    DASH    = 7'b1000000;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0111111;
            4'd1:    s = 7'b0000110;
            4'd2:    s = 7'b1011011;
            4'd3:    s = 7'b1001111;
            4'd4:    s = 7'b1100110;
            4'd5:    s = 7'b1101101;
            4'd6:    s = 7'b1111101;
            4'd7:    s = 7'b0000111;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1101111;
            default: s = DASH;
        endcase
        return s;
    endfunction

    // Reset asserts asynchronously but releases only after two clean clock edges.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rst_sync_q <= 2'b00;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    state_t                    state_q, state_d;
    logic [3:0]                cnt_q, cnt_d;
    logic [4*(CODE_LEN-1)-1:0] buf_q, buf_d;
    logic [4*CODE_LEN-1:0]     code_q, code_d;
    logic [6:0]                disp_q, disp_d;
    logic [3:0]                tries_q, tries_d;
    logic [TW-1:0]             timer_q, timer_d;
    logic                      erro_q, erro_d;
    logic                      led_q, led_d;
    logic                      bloq_q, bloq_d;
    logic [4*CODE_LEN-1:0]     full;
    logic                      valid;

    assign full  = {buf_q, numero};
    assign valid = insere && (numero <= 4'd9);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        code_d  = code_q;
        disp_d  = disp_q;
        tries_d = tries_q;
        erro_d  = 1'b0;
        timer_d = (timer_q == T_SAT) ? timer_q : timer_q + TW'(1);

        case (state_q)
            ST_ENTRY: begin
                if (insere) begin
                    timer_d = '0;
                    disp_d  = valid ? seg7(numero) : DASH;
                    if (valid) begin
                        if (cnt_q == LAST) begin
                            cnt_d = '0;
                            buf_d = '0;
                            if (full == code_q) begin
                                state_d = ST_OPEN;
                                tries_d = '0;
                            end else begin
                                erro_d = 1'b1;
                                if (tries_q + 4'd1 >= MAXT) begin
                                    tries_d = MAXT;
                                    state_d = ST_LOCK;
                                end else begin
                                    tries_d = tries_q + 4'd1;
                                end
                            end
                        end else begin
                            buf_d = full[4*(CODE_LEN-1)-1:0];
                            cnt_d = cnt_q + 4'd1;
                        end
                    end
                end else if (cnt_q != 4'd0 && timer_q == TO_LAST) begin
                    cnt_d  = '0;
                    buf_d  = '0;
                    disp_d = '0;
                end
            end

            ST_OPEN: begin
                if (trava) begin
                    state_d = ST_ENTRY;
                    disp_d  = '0;
                    timer_d = '0;
                end else if (programa) begin
                    state_d = ST_PROG;
                    cnt_d   = '0;
                    buf_d   = '0;
                    timer_d = '0;
                end else if (timer_q == TO_LAST) begin
                    state_d = ST_ENTRY;
                    disp_d  = '0;
                    timer_d = '0;
                end
            end

            ST_PROG: begin
                if (insere) begin
                    timer_d = '0;
                    disp_d  = valid ? seg7(numero) : DASH;
                    if (valid) begin
                        if (cnt_q == LAST) begin
                            code_d  = full;
                            state_d = ST_OPEN;
                            cnt_d   = '0;
                            buf_d   = '0;
                        end else begin
                            buf_d = full[4*(CODE_LEN-1)-1:0];
                            cnt_d = cnt_q + 4'd1;
                        end
                    end
                end else if (timer_q == TO_LAST) begin
                    state_d = ST_OPEN;
                    cnt_d   = '0;
                    buf_d   = '0;
                    timer_d = '0;
                end
            end

            default: begin
                // Lockout timer runs from entry; strobes neither restart it nor register.
                if (timer_q == LK_LAST) begin
                    state_d = ST_ENTRY;
                    tries_d = '0;
                    cnt_d   = '0;
                    buf_d   = '0;
                    disp_d  = '0;
                    timer_d = '0;
                end
            end
        endcase

        if (state_d != state_q) timer_d = '0;

        led_d  = (state_d == ST_OPEN) || (state_d == ST_PROG);
        bloq_d = (state_d == ST_LOCK);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_ENTRY;
            cnt_q   <= '0;
            buf_q   <= '0;
            code_q  <= DEFAULT_CODE;
            disp_q  <= '0;
            tries_q <= '0;
            timer_q <= '0;
            erro_q  <= 1'b0;
            led_q   <= 1'b0;
            bloq_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            code_q  <= code_d;
            disp_q  <= disp_d;
            tries_q <= tries_d;
            timer_q <= timer_d;
            erro_q  <= erro_d;
            led_q   <= led_d;
            bloq_q  <= bloq_d;
        end
    end

    assign estado     = cnt_q;
    assign modo       = state_q;
    assign display    = disp_q;
    assign led        = led_q;
    assign bloqueado  = bloq_q;
    assign erro       = erro_q;
    assign tentativas = tries_q;

endmodule

// File: tb/tb_controlador_senha_param.sv
// Scoreboard bench for controlador_senha_param: a behavioural lock model predicts
// every registered output one edge after each driven input cycle.
module tb_controlador_senha_param;

    localparam int CL = 6;
    localparam int MT = 3;
    localparam int LK = 16;
    localparam int TO = 32;
    localparam int W  = 20;

    logic       clk = 1'b0;
    logic       reset;
    logic       insere;
    logic [3:0] numero;
    logic       programa;
    logic       trava;
    logic [3:0] estado;
    logic [1:0] modo;
    logic [6:0] display;
    logic       led;
    logic       bloqueado;
    logic       erro;
    logic [3:0] tentativas;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] exp_q[$];

    controlador_senha_param dut (
        .clk       (clk),
        .reset     (reset),
        .insere    (insere),
        .numero    (numero),
        .programa  (programa),
        .trava     (trava),
        .estado    (estado),
        .modo      (modo),
        .display   (display),
        .led       (led),
        .bloqueado (bloqueado),
        .erro      (erro),
        .tentativas(tentativas)
    );

    // clock / reset
    always #5 clk = ~clk;

    // behavioural model of the lock
    logic [6:0] seg_tab [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                                 7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};
    int         m_mode, m_cnt, m_tries, m_idle;
    int         m_dig [CL];
    int         m_code[CL];
    logic [6:0] m_disp;
    logic       m_erro;

    task automatic model_reset();
        int def[CL] = '{5, 8, 9, 2, 0, 4};
        m_mode = 0; m_cnt = 0; m_tries = 0; m_idle = 0;
        m_disp = 7'd0; m_erro = 1'b0;
        for (int i = 0; i < CL; i++) begin
            m_code[i] = def[i];
            m_dig[i]  = 0;
        end
    endtask

    task automatic model_step(input bit ins, input int num, input bit prog, input bit trv);
        int  old_mode;
        bit  ok;
        old_mode = m_mode;
        m_erro   = 1'b0;
        case (m_mode)
            0: begin
                if (ins) begin
                    m_idle = 0;
                    if (num > 9) m_disp = 7'b1000000;
                    else begin
                        m_disp = seg_tab[num];
                        m_dig[m_cnt] = num;
                        m_cnt++;
                        if (m_cnt == CL) begin
                            m_cnt = 0;
                            ok = 1'b1;
                            for (int i = 0; i < CL; i++) if (m_dig[i] != m_code[i]) ok = 1'b0;
                            if (ok) begin
                                m_mode = 1; m_tries = 0;
                            end else begin
                                m_erro = 1'b1;
                                m_tries++;
                                if (m_tries >= MT) begin m_tries = MT; m_mode = 3; end
                            end
                        end
                    end
                end else begin
                    m_idle++;
                    if (m_cnt > 0 && m_idle >= TO) begin m_cnt = 0; m_disp = 7'd0; end
                end
            end
            1: begin
                m_idle++;
                if (trv) begin m_mode = 0; m_disp = 7'd0; end
                else if (prog) begin m_mode = 2; m_cnt = 0; end
                else if (m_idle >= TO) begin m_mode = 0; m_disp = 7'd0; end
            end
            2: begin
                if (ins) begin
                    m_idle = 0;
                    if (num > 9) m_disp = 7'b1000000;
                    else begin
                        m_disp = seg_tab[num];
                        m_dig[m_cnt] = num;
                        m_cnt++;
                        if (m_cnt == CL) begin
                            for (int i = 0; i < CL; i++) m_code[i] = m_dig[i];
                            m_cnt = 0; m_mode = 1;
                        end
                    end
                end else begin
                    m_idle++;
                    if (m_idle >= TO) begin m_mode = 1; m_cnt = 0; end
                end
            end
            default: begin
                m_idle++;
                if (m_idle >= LK) begin m_mode = 0; m_tries = 0; m_cnt = 0; m_disp = 7'd0; end
            end
        endcase
        if (m_mode != old_mode) m_idle = 0;
    endtask

    function automatic logic [W-1:0] model_vec();
        return {2'(m_mode), 4'(m_cnt), m_disp, (m_mode == 1 || m_mode == 2),
                (m_mode == 3), m_erro, 4'(m_tries)};
    endfunction

    // checking
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%h expected=%h", tag, $time, got, want);
        end
    endtask

    // scoreboard: pop one expectation per edge that follows a driven cycle
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0)
            check("outputs{modo,estado,display,led,bloq,erro,tent}",
                  32'({modo, estado, display, led, bloqueado, erro, tentativas}),
                  32'(exp_q.pop_front()));
    end

    // drivers
    task automatic drive(input bit ins, input logic [3:0] num, input bit prog, input bit trv);
        @(negedge clk);
        insere = ins; numero = num; programa = prog; trava = trv;
        model_step(ins, int'(num), prog, trv);
        exp_q.push_back(model_vec());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic enter_code(input logic [23:0] code);
        for (int i = CL - 1; i >= 0; i--) drive(1'b1, code[4*i +: 4], 1'b0, 1'b0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_modo"}, 32'(modo), 32'd0);
        check({tag, "_estado"}, 32'(estado), 32'd0);
        check({tag, "_display"}, 32'(display), 32'd0);
        check({tag, "_led"}, 32'(led), 32'd0);
        check({tag, "_bloq"}, 32'(bloqueado), 32'd0);
        check({tag, "_erro"}, 32'(erro), 32'd0);
        check({tag, "_tent"}, 32'(tentativas), 32'd0);
    endtask

    // asynchronous reset between edges, checked before any clock edge
    task automatic async_reset(input string tag);
        @(negedge clk);
        insere = 1'b0; programa = 1'b0; trava = 1'b0;
        #2 reset = 1'b0;
        #1 check_reset_values(tag);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        idle(3);
    endtask

    initial begin
        reset = 1'b0; insere = 1'b0; numero = 4'd0; programa = 1'b0; trava = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_values("por");
        reset = 1'b1;
        idle(3);

        // correct default code opens, then relock
        enter_code(24'h589204);
        idle(2);
        drive(1'b0, 4'd0, 1'b0, 1'b1);
        idle(1);

        // wrong code with an invalid digit in the middle
        drive(1'b1, 4'd5, 1'b0, 1'b0);
        drive(1'b1, 4'd7, 1'b0, 1'b0);
        drive(1'b1, 4'd8, 1'b0, 1'b0);
        drive(1'b1, 4'd10, 1'b0, 1'b0);
        drive(1'b1, 4'd0, 1'b0, 1'b0);
        drive(1'b1, 4'd1, 1'b0, 1'b0);
        drive(1'b1, 4'd2, 1'b0, 1'b0);
        idle(1);

        // two more failures reach lockout; correct code during lockout is ignored
        enter_code(24'h111111);
        enter_code(24'h999999);
        enter_code(24'h589204);
        idle(12);

        // partial entry abandoned after inactivity, then open
        drive(1'b1, 4'd5, 1'b0, 1'b0);
        drive(1'b1, 4'd8, 1'b0, 1'b0);
        idle(TO + 1);
        enter_code(24'h589204);

        // reprogram while open, relock, old code fails, new code opens
        drive(1'b0, 4'd0, 1'b1, 1'b0);
        enter_code(24'h123456);
        drive(1'b0, 4'd0, 1'b1, 1'b1);
        enter_code(24'h589204);
        enter_code(24'h123456);

        // open-state inactivity returns to entry
        idle(TO + 2);

        // reset mid-entry reverts the code register
        drive(1'b1, 4'd1, 1'b0, 1'b0);
        drive(1'b1, 4'd2, 1'b0, 1'b0);
        drive(1'b1, 4'd3, 1'b0, 1'b0);
        async_reset("rst_entry");
        enter_code(24'h589204);
        drive(1'b0, 4'd0, 1'b0, 1'b1);

        // random traffic
        for (int i = 0; i < 300; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 6)       drive(1'b1, 4'($urandom_range(0, 11)), 1'b0, 1'b0);
            else if (r == 6) drive(1'b0, 4'd0, 1'b1, 1'b0);
            else if (r == 7) drive(1'b0, 4'd0, 1'b0, 1'b1);
            else             drive(1'b0, 4'd0, 1'b0, 1'b0);
        end
        async_reset("rst_rand");

        // reset mid-lockout
        enter_code(24'h000000);
        enter_code(24'h000001);
        enter_code(24'h000002);
        idle(5);
        async_reset("rst_lock");
        enter_code(24'h589204);
        idle(2);

        @(negedge clk);
        @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/controlador_senha_param.md
Name: controlador_senha_param

Overview:
Parametrised successor to the fixed 6-digit keypad lock controller. It collects BCD digits strobed on `insere` and compares a complete code of CODE_LEN digits in one step. It counts failed attempts and enters a timed lockout after MAX_TRIES failures. It clears partial entries after a period of inactivity and lets the code be reprogrammed while unlocked. It sits between the keypad/debounce front end and the lock actuator plus 7-segment display.

Parameters:
CODE_LEN, 6, digits per code (2..15).
MAX_TRIES, 3, consecutive failed attempts that trigger lockout (1..15).
LOCKOUT_CYCLES, 16, clock cycles spent in lockout.
TIMEOUT_CYCLES, 32, idle cycles before a partial entry or open state is abandoned.
DEFAULT_CODE, 24'h589204, reset code, 4*CODE_LEN bits; the first digit is in the most significant nibble.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
insere  in  1  digit strobe; one digit is sampled on every rising edge where insere=1.
numero  in  4  BCD digit; values above 9 are invalid.
programa  in  1  level; while OPEN, a sampled 1 enters PROG.
trava  in  1  level; while OPEN, a sampled 1 relocks the controller.
estado  out  4  number of digits accepted in the current entry (0..CODE_LEN-1).
modo  out  2  FSM state: 0=ENTRY, 1=OPEN, 2=PROG, 3=LOCKOUT.
display  out  7  {g,f,e,d,c,b,a}, active-high; shows the last accepted digit.
led  out  1  1 while OPEN or PROG.
bloqueado  out  1  1 while in LOCKOUT.
erro  out  1  one-cycle pulse on a failed complete code.
tentativas  out  4  consecutive failure count.

Behaviour:
- Reset (reset=0, asynchronous): modo=ENTRY, estado=0, display=0 (blank), led=0, bloqueado=0, erro=0, tentativas=0, code register=DEFAULT_CODE, digit buffer and timers cleared. Release of reset is synchronised internally.
- All outputs are registered. Each response appears after the clock edge that samples the causing input.
- Valid digit: insere=1 with numero<=9. Invalid digit: insere=1 with numero>9.
  - An invalid digit is ignored: estado is unchanged, it is not counted as a failure, and display shows a dash (segment g only).
  - Any strobe, valid or invalid, restarts the inactivity timer.
- ENTRY state:
  - A valid digit is shifted into the buffer and estado increments.
  - On the CODE_LEN-th valid digit, buffer plus incoming digit are compared to the code register on that same edge. estado returns to 0.
  - Match: go to OPEN, tentativas=0.
  - Mismatch: erro pulses for 1 cycle and tentativas increments. If the new count equals MAX_TRIES, go to LOCKOUT; otherwise stay in ENTRY.
  - No digit-by-digit early rejection; a wrong code is reported only when complete.
  - Inactivity for TIMEOUT_CYCLES with estado>0: buffer cleared, estado=0, display blank, no failure counted.
- OPEN state:
  - Priority: trava=1 takes precedence over programa=1. trava returns to ENTRY; programa goes to PROG.
  - insere is ignored in OPEN.
  - Inactivity for TIMEOUT_CYCLES (counted since entering OPEN) returns to ENTRY.
- PROG state:
  - Valid digits fill a staging buffer and estado counts them.
  - On the CODE_LEN-th digit, the staging buffer is copied to the code register and the FSM returns to OPEN with estado=0.
  - Inactivity for TIMEOUT_CYCLES aborts to OPEN; the code register is unchanged.
  - trava and programa are ignored in PROG.
- LOCKOUT state:
  - bloqueado=1 and all inputs are ignored.
  - Strobes do not restart the lockout timer.
  - After exactly LOCKOUT_CYCLES cycles: go to ENTRY, tentativas=0, bloqueado=0.
- display encoding for 0..9 uses standard 7-segment patterns, e.g. 5=7'b1101101 and 8=7'b1111111.
  - display blanks whenever the FSM enters ENTRY from OPEN, LOCKOUT or a timeout.
- Timer width: clog2(max(LOCKOUT_CYCLES, TIMEOUT_CYCLES)+1). Timers saturate and never wrap.
- tentativas saturates at MAX_TRIES.
- Reset mid-entry, mid-PROG or mid-lockout returns everything to reset values, including code register=DEFAULT_CODE.

Test Plan:
- Reset, then digits 5,8,9,2,0,4 on consecutive cycles -> estado steps 1..5 then 0; modo=1 and led=1 after the 6th edge; tentativas=0.
- Digits 5,7,8,10,0,1,2 -> the 10 is ignored and display=7'b1000000; erro pulses after the 6th valid digit; tentativas=1; modo=0.
- Three wrong 6-digit codes -> bloqueado=1 and modo=3 after the 3rd. Strobing 5,8,9,2,0,4 during lockout has no effect. Exactly 16 cycles later modo=0 and tentativas=0.
- Enter 5,8 then idle 32 cycles -> estado=0, no erro. Then 5,8,9,2,0,4 -> opens.
- While OPEN: programa=1, digits 1,2,3,4,5,6, then trava=1. Code 589204 -> erro. Code 123456 -> led=1.
- Assert reset=0 mid-entry after 3 digits and mid-lockout -> all outputs at reset values immediately (asynchronous); code reverts to 589204.
